// File: rtl/wb_gpio_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : wb_gpio_pkg
// Purpose  : Register map and decode helpers shared by the GPIO block.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package wb_gpio_pkg;

  // Byte offsets of the four 32-bit registers.
  localparam logic [31:0] OFS_DOUT = 32'h0000_0000;
  localparam logic [31:0] OFS_DIR  = 32'h0000_0004;
  localparam logic [31:0] OFS_DIN  = 32'h0000_0008;
  localparam logic [31:0] OFS_IRQ  = 32'h0000_000C;

  // Register select, derived from address bits [3:2] of the offsets.
  typedef enum logic [1:0] {
    SEL_DOUT = 2'(OFS_DOUT >> 2),
    SEL_DIR  = 2'(OFS_DIR  >> 2),
    SEL_DIN  = 2'(OFS_DIN  >> 2),
    SEL_IRQ  = 2'(OFS_IRQ  >> 2)
  } reg_sel_e;

  // Only word-select bits take part in decoding.
  function automatic reg_sel_e decode_sel(input logic [1:0] word_adr);
    return reg_sel_e'(word_adr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : gpio_sync
// Purpose  : Per-bit two-flop synchroniser for asynchronous pin inputs.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module gpio_sync #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_gpio.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : wb_gpio
// Purpose  : Wishbone-slave GPIO with direction control, synchronised inputs
//            and rising-edge interrupt status (W1C) with per-bit enables.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int NGPIO = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic [31:0]      wbs_dat_o,
  output logic             wbs_ack_o,
  input  logic [NGPIO-1:0] gpio_i,
  output logic [NGPIO-1:0] gpio_o,
  output logic [NGPIO-1:0] gpio_oe_o,
  output logic             irq_o
);

  logic [NGPIO-1:0] dout;
  logic [NGPIO-1:0] dir;
  logic [NGPIO-1:0] irq_status;
  logic [NGPIO-1:0] irq_enable;
  logic [NGPIO-1:0] sync2;
  logic [NGPIO-1:0] sync3;
  logic [NGPIO-1:0] rise;
  logic [NGPIO-1:0] status_next;
  logic [31:0]      rdata;
  logic             req;
  logic             wr;
  reg_sel_e         sel;
  logic             unused_bits;

  // Address bits outside [3:2] are don't-care for this slave.
  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

  // The ~ack term makes a held strobe see one request every other cycle.
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr  = req & wbs_we_i;
  assign sel = decode_sel(wbs_adr_i[3:2]);

  assign gpio_o    = dout;
  assign gpio_oe_o = dir;

  gpio_sync #(
    .WIDTH (NGPIO)
  ) u_sync (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (gpio_i),
    .dout (sync2)
  );

  assign rise = sync2 & ~sync3;

  // Read mux; unimplemented bits read as zero.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_DOUT: rdata[NGPIO-1:0] = dout;
      SEL_DIR:  rdata[NGPIO-1:0] = dir;
      SEL_DIN:  rdata[NGPIO-1:0] = sync2;
      SEL_IRQ: begin
        rdata[NGPIO-1:0]  = irq_status;
        rdata[16 +: NGPIO] = irq_enable;
      end
      default:  rdata = '0;
    endcase
  end

  // W1C clear first, then OR in new edges so an edge beats a same-cycle clear.
  always_comb begin
    status_next = irq_status;
    if (wr && sel == SEL_IRQ) begin
      status_next = status_next & ~wbs_dat_i[NGPIO-1:0];
    end
    status_next = status_next | rise;
  end

  // Bus handshake: one-cycle ack and read data registered on the request cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0;
    end
  end

  // Writable control registers; DIN writes fall through and are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout       <= '0;
      dir        <= '0;
      irq_enable <= '0;
    end else if (wr) begin
      case (sel)
        SEL_DOUT: dout       <= wbs_dat_i[NGPIO-1:0];
        SEL_DIR:  dir        <= wbs_dat_i[NGPIO-1:0];
        SEL_IRQ:  irq_enable <= wbs_dat_i[16 +: NGPIO];
        default:  ;
      endcase
    end
  end

  // Edge history, interrupt status and the registered interrupt line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync3      <= '0;
      irq_status <= '0;
      irq_o      <= 1'b0;
    end else begin
      sync3      <= sync2;
      irq_status <= status_next;
      irq_o      <= |(irq_status & irq_enable);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_wb_gpio
// Purpose  : Directed self-checking bench for wb_gpio with a read scoreboard.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_wb_gpio;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [31:0] rdat;
  logic        ack;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    string       name;
  } sb_item_t;

  sb_item_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_gpio #(.NGPIO(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_dat_o (rdat),
    .wbs_ack_o (ack),
    .gpio_i    (gpio_in),
    .gpio_o    (gpio_out),
    .gpio_oe_o (gpio_oe),
    .irq_o     (irq)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected transfer; reads also compare data.
  always @(negedge clk) begin
    if (ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
      end else begin
        sb_item_t it;
        it = exp_q.pop_front();
        if (it.is_read) check(it.name, rdat, it.data);
      end
    end
  end

  // Single transfer; checks ack one cycle after strobe and gone one cycle later.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input string nm);
    sb_item_t it;
    it.is_read = !w;
    it.data    = exp_rd;
    it.name    = nm;
    @(posedge clk); #1;
    exp_q.push_back(it);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk); #1;
    check({nm, "_ack"}, 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check({nm, "_ack_drop"}, 32'(ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ack_cnt;
    sb_item_t it;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; gpio_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio_o", 32'(gpio_out), 32'h0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", rdat, 32'h0);
    rst = 1'b0;

    // Direction and output registers drive the pins directly.
    wb_xfer(1'b1, 32'h4, 32'h0000_A5A5, 32'h0, "wr_dir");
    check("gpio_oe", 32'(gpio_oe), 32'h0000_A5A5);
    wb_xfer(1'b1, 32'h0, 32'h0000_FFFF, 32'h0, "wr_dout");
    check("gpio_o", 32'(gpio_out), 32'h0000_FFFF);
    wb_xfer(1'b0, 32'h0, 32'h0, 32'h0000_FFFF, "rd_dout");
    wb_xfer(1'b0, 32'h4, 32'h0, 32'h0000_A5A5, "rd_dir");

    // Synchronised input readback; DIN is read-only.
    @(posedge clk); #1;
    gpio_in = 16'h1234;
    repeat (3) @(posedge clk);
    wb_xfer(1'b0, 32'h8, 32'h0, 32'h0000_1234, "rd_din");
    wb_xfer(1'b1, 32'h8, 32'h0000_FFFF, 32'h0, "wr_din");
    wb_xfer(1'b0, 32'h8, 32'h0, 32'h0000_1234, "rd_din_after_wr");

    // Pins 1234 caused rising edges: status visible, enable still zero.
    wb_xfer(1'b0, 32'hC, 32'h0, 32'h0000_1234, "rd_irq_edges");
    check("irq_disabled", 32'(irq), 32'h0);
    wb_xfer(1'b1, 32'hC, 32'h0000_FFFF, 32'h0, "clr_all");
    @(posedge clk); #1;
    gpio_in = 16'h0000;
    repeat (4) @(posedge clk);
    wb_xfer(1'b0, 32'hC, 32'h0, 32'h0, "rd_irq_clear");

    // Enable bit 0, raise pin 0, see the interrupt, then W1C it.
    wb_xfer(1'b1, 32'hC, 32'h0001_0000, 32'h0, "wr_irq_en");
    @(posedge clk); #1;
    gpio_in = 16'h0001;
    repeat (4) @(posedge clk);
    #1;
    check("irq_set", 32'(irq), 32'h1);
    wb_xfer(1'b0, 32'hC, 32'h0, 32'h0001_0001, "rd_irq_status");
    wb_xfer(1'b1, 32'hC, 32'h0000_0001, 32'h0, "w1c_bit0");
    check("irq_cleared", 32'(irq), 32'h0);
    wb_xfer(1'b0, 32'hC, 32'h0, 32'h0, "rd_after_w1c");

    // Edge on pin 0 lands on the same edge as a W1C of bit 0: set wins.
    @(posedge clk); #1;
    gpio_in = 16'h0000;
    repeat (4) @(posedge clk);
    #1;
    gpio_in = 16'h0001;
    @(posedge clk);
    wb_xfer(1'b1, 32'hC, 32'h0000_0001, 32'h0, "w1c_race");
    wb_xfer(1'b0, 32'hC, 32'h0, 32'h0000_0001, "rd_set_wins");

    // Held strobe on a read for six cycles yields three acks.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      it.is_read = 1'b1;
      it.data    = 32'h0000_FFFF;
      it.name    = "held_rd";
      exp_q.push_back(it);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_ack_c%0d", i), 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      ack_cnt += int'(ack);
    end
    cyc = 1'b0; stb = 1'b0;
    check("held_ack_count", 32'(ack_cnt), 32'd3);

    // Reset on the request cycle of a write aborts it.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; wdat = 32'h0000_FFFF;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ack", 32'(ack), 32'h0);
    check("abort_gpio_o", 32'(gpio_out), 32'h0);
    check("abort_gpio_oe", 32'(gpio_oe), 32'h0);
    check("abort_irq", 32'(irq), 32'h0);
    check("abort_dat", rdat, 32'h0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_xfer(1'b0, 32'h0, 32'h0, 32'h0, "rd_dout_after_abort");

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_gpio.md
WB_GPIO -- requirements
Module: wb_gpio

Interface
REQ-001 SHALL have parameter: NGPIO, 16, number of GPIO pins, legal range 1..16.
REQ-002 SHALL have port: clk_i  input  1  single clock, all state updated on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: wbs_cyc_i  input  1  Wishbone cycle.
REQ-005 SHALL have port: wbs_stb_i  input  1  Wishbone strobe.
REQ-006 SHALL have port: wbs_we_i  input  1  write enable.
REQ-007 SHALL have port: wbs_adr_i  input  32  byte address; only bits [3:2] decoded.
REQ-008 SHALL have port: wbs_dat_i  input  32  write data.
REQ-009 SHALL have port: wbs_dat_o  output  32  read data.
REQ-010 SHALL have port: wbs_ack_o  output  1  transfer acknowledge.
REQ-011 SHALL have port: gpio_i  input  NGPIO  asynchronous pin inputs.
REQ-012 SHALL have port: gpio_o  output  NGPIO  pin output values.
REQ-013 SHALL have port: gpio_oe_o  output  NGPIO  pin output enables, 1 = drive.
REQ-014 SHALL have port: irq_o  output  1  level interrupt request.

Function
REQ-015 SHALL decode registers by wbs_adr_i[3:2]: 0 = DOUT (RW), 1 = DIR (RW), 2 = DIN (RO), 3 = IRQ (status [15:0] W1C, enable [31:16] RW).
REQ-016 SHALL treat a request as req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o.
REQ-017 SHALL assert wbs_ack_o, registered, exactly one cycle after req and for one cycle only; the ~wbs_ack_o term makes a held strobe complete one transfer every 2 cycles.
REQ-018 SHALL perform a write on the req cycle, so the new register value is visible in the same cycle that ack rises.
REQ-019 SHALL register wbs_dat_o on the req cycle; it is valid while ack is high and reads 0 when ack is low.
REQ-020 SHALL return 0 for register bits at or above NGPIO (and at or above 16+NGPIO in IRQ); writes to those bits are ignored.
REQ-021 SHALL ignore writes to DIN; they are still acked.
REQ-022 SHALL drive gpio_o = DOUT[NGPIO-1:0] and gpio_oe_o = DIR[NGPIO-1:0] directly from registers.
REQ-023 SHALL synchronise gpio_i through 2 flops; DIN reads the second flop, so latency from a pin change to DIN is 2-3 cycles.
REQ-024 SHALL keep a third flop (previous synced value) and detect a rising edge per bit as sync2 & ~sync3.
REQ-025 SHALL set status bit n on a rising edge of pin n, regardless of the enable bit.
REQ-026 SHALL clear status bit n when an IRQ write has data bit n = 1; bits written 0 are unchanged.
REQ-027 SHALL let set win over clear when an edge and a W1C hit the same bit in the same cycle.
REQ-028 SHALL register irq_o = |(status & enable), so irq_o lags the status/enable change by 1 cycle.
REQ-029 SHALL accept reads and writes regardless of DIR; DIN always reflects the pins.

Reset
REQ-030 SHALL, while rst_i is high at a clock edge, clear DOUT, DIR, IRQ status, IRQ enable, the synchroniser flops, wbs_ack_o, wbs_dat_o and irq_o to 0.
REQ-031 SHALL abort an in-flight transfer if rst_i rises mid-transfer: no ack is produced and any pending write is discarded.
REQ-032 SHALL detect no edge in the first cycle after reset, because the sync flops all start at 0 together.

Structure
REQ-033 SHALL place the register offsets (DOUT 0x0, DIR 0x4, DIN 0x8, IRQ 0xC) in shared package wb_gpio_pkg.
REQ-034 SHALL implement the per-bit 2-flop synchroniser as sub-module gpio_sync (parameter WIDTH), instantiated once.

Verification
REQ-035 SHALL cover: write 0x0000A5A5 to 0x4, then 0x0000FFFF to 0x0 -> gpio_oe_o = 0xA5A5, gpio_o = 0xFFFF; each ack is 1 cycle, 1 cycle after stb.
REQ-036 SHALL cover: gpio_i = 0x1234, wait 3 cycles, read 0x8 -> wbs_dat_o = 0x00001234 with ack; a write of 0xFFFF to 0x8 is acked and DIN is unchanged.
REQ-037 SHALL cover: write 0x00010000 to 0xC, drive gpio_i[0] 0->1 -> status[0] = 1, irq_o = 1; read 0xC = 0x00010001; write 0x00000001 to 0xC -> status 0, irq_o = 0 the next cycle.
REQ-038 SHALL cover: a new gpio_i[0] rising edge in the same cycle as the W1C of bit 0 -> status[0] stays 1.
REQ-039 SHALL cover: cyc/stb held high for 6 cycles on a read -> exactly 3 ack pulses, alternating cycles.
REQ-040 SHALL cover: assert rst_i on the req cycle of a write of 0xFFFF to 0x0 -> no ack, DOUT = 0, all outputs 0.
